// File: rtl/iddr_gearbox_align.sv
// iddr_gearbox_align
//   Multi-channel input DDR gearbox. Takes per-channel rise/fall sample pairs
//   from the pin capture cells and deserialises them 1:RATIO into words. It
//   applies a bit-granular slip and runs a training-pattern lock FSM on
//   channel 0.
// Ports
//   ECLK      clock, all state updates on posedge
//   RST       synchronous active-high reset, highest priority
//   DR / DF   rising (older) / falling (newer) sample per channel
//   SLIP      external slip request pulse (ignored during training)
//   RUNAIL    rising edge starts alignment training
//   RSTAIL    synchronous clear of alignment state
//   Q         channel c word = Q[c*RATIO +: RATIO], MSB oldest
//   UPDATE    one-cycle strobe, Q newly valid
//   LOCK      alignment achieved
//   SLIP_POS  current slip position, 0..RATIO-1
module iddr_gearbox_align #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      RATIO     = 4,
  parameter logic [RATIO-1:0] TRAIN_PAT = 4'b1100,
  parameter int unsigned      LOCK_CNT  = 32,
  parameter bit               AUTO_SLIP = 1'b1
) (
  input  logic                     ECLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         DR,
  input  logic [WIDTH-1:0]         DF,
  input  logic                     SLIP,
  input  logic                     RUNAIL,
  input  logic                     RSTAIL,
  output logic [WIDTH*RATIO-1:0]   Q,
  output logic                     UPDATE,
  output logic                     LOCK,
  output logic [$clog2(RATIO)-1:0] SLIP_POS
);

  localparam int unsigned Half  = RATIO / 2;
  localparam int unsigned PhW   = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned PosW  = $clog2(RATIO);
  localparam int unsigned BusyW = $clog2(Half + 1);

  localparam logic [PhW-1:0]   PhLast    = PhW'(Half - 1);
  localparam logic [PosW-1:0]  PosLast   = PosW'(RATIO - 1);
  localparam logic [BusyW-1:0] BusyLoad  = BusyW'(Half);
  localparam logic [7:0]       MatchLast = 8'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StIdle, StTrain, StLocked} state_e;

  state_e                      state_q, state_d;
  logic [7:0]                  match_q, match_d;
  logic [WIDTH-1:0][RATIO:0]   shbuf_q, shbuf_d;
  logic [WIDTH*RATIO-1:0]      word_d, q_q;
  logic                        upd_q;
  logic [PhW-1:0]              ph_q;
  logic                        boff_q;
  logic [PosW-1:0]             pos_q;
  logic [BusyW-1:0]            busy_q;
  logic                        runail_q;

  logic rise, busy, match, slip_req, slip_acc, hold, strobe;

  // Shift buffers and word extraction from the post-shift buffer value.
  always_comb begin
    shbuf_d = '0;
    word_d  = '0;
    for (int c = 0; c < WIDTH; c++) begin
      shbuf_d[c] = {shbuf_q[c][RATIO-2:0], DR[c], DF[c]};
      word_d[c*RATIO +: RATIO] = boff_q ? shbuf_d[c][RATIO:1] : shbuf_d[c][RATIO-1:0];
    end
  end

  // Slip arbitration. Training owns the slip source; external SLIP only
  // acts outside training. Internal slips yield to RSTAIL and a new rise.
  always_comb begin
    rise  = RUNAIL & ~runail_q;
    busy  = (busy_q != '0);
    match = (q_q[RATIO-1:0] == TRAIN_PAT);
    if (state_q == StTrain) begin
      slip_req = AUTO_SLIP && upd_q && !match && !RSTAIL && !rise;
    end else begin
      slip_req = SLIP;
    end
    slip_acc = slip_req & ~busy;
    // Leaving boff=1 for boff=0 costs one frame cycle: the word lands 2 bits later.
    hold     = slip_acc & boff_q;
    strobe   = (ph_q == PhLast) & ~hold;
  end

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (RSTAIL) begin
      state_d = StIdle;
      match_d = '0;
    end else if (rise) begin
      state_d = StTrain;
      match_d = '0;
    end else if (state_q == StTrain && upd_q) begin
      if (match) begin
        match_d = match_q + 8'd1;
        if (match_q == MatchLast) begin
          state_d = StLocked;
        end
      end else begin
        match_d = '0;
      end
    end
  end

  always_ff @(posedge ECLK) begin
    if (RST) begin
      state_q <= StIdle;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge ECLK) begin
    if (RST) begin
      shbuf_q  <= '0;
      q_q      <= '0;
      upd_q    <= 1'b0;
      ph_q     <= '0;
      boff_q   <= 1'b0;
      pos_q    <= '0;
      busy_q   <= '0;
      runail_q <= 1'b0;
    end else begin
      shbuf_q  <= shbuf_d;
      runail_q <= RUNAIL;
      upd_q    <= strobe;
      if (strobe) begin
        q_q <= word_d;
      end
      if (!hold) begin
        ph_q <= (ph_q == PhLast) ? '0 : ph_q + 1'b1;
      end
      if (slip_acc) begin
        boff_q <= ~boff_q;
        pos_q  <= (pos_q == PosLast) ? '0 : pos_q + 1'b1;
        busy_q <= BusyLoad;
      end else if (busy) begin
        busy_q <= busy_q - 1'b1;
      end
    end
  end

  assign Q        = q_q;
  assign UPDATE   = upd_q;
  assign LOCK     = (state_q == StLocked);
  assign SLIP_POS = pos_q;

endmodule

// File: tb/tb_iddr_gearbox_align.sv
// tb_iddr_gearbox_align
//   Self-checking bench for iddr_gearbox_align with WIDTH=2, RATIO=4,
//   LOCK_CNT=4, TRAIN_PAT=4'b1100. A vector table covers reset and basic
//   deserialisation; hand sequences cover slip, training, RSTAIL and RST.
//   Channel 1 always carries the inverse of channel 0 in the sequences.
module tb_iddr_gearbox_align;

  logic       ECLK;
  logic       RST, SLIP, RUNAIL, RSTAIL;
  logic [1:0] DR, DF;
  logic [7:0] Q;
  logic       UPDATE, LOCK;
  logic [1:0] SLIP_POS;

  iddr_gearbox_align #(
    .WIDTH    (2),
    .RATIO    (4),
    .TRAIN_PAT(4'b1100),
    .LOCK_CNT (4),
    .AUTO_SLIP(1'b1)
  ) dut (
    .ECLK    (ECLK),
    .RST     (RST),
    .DR      (DR),
    .DF      (DF),
    .SLIP    (SLIP),
    .RUNAIL  (RUNAIL),
    .RSTAIL  (RSTAIL),
    .Q       (Q),
    .UPDATE  (UPDATE),
    .LOCK    (LOCK),
    .SLIP_POS(SLIP_POS)
  );

  initial ECLK = 1'b0;
  always #5 ECLK = ~ECLK;

  int checks = 0;
  int errors = 0;

  logic [3:0] pat;  // repeating channel-0 word pattern, MSB first
  int         pi;   // which bit pair of pat is fed next (0 or 1)

  typedef struct {
    logic       rst;
    logic [1:0] dr;   // {ch1, ch0}
    logic [1:0] df;
    logic [7:0] q;
    logic       upd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Feed the next bit pair of pat on ch0 (inverse on ch1), then sample #1 after the edge.
  task automatic step(input logic rst, input logic slip, input logic runail, input logic rstail);
    logic br, bf;
    br     = pat[3 - 2*pi];
    bf     = pat[2 - 2*pi];
    RST    = rst;
    SLIP   = slip;
    RUNAIL = runail;
    RSTAIL = rstail;
    DR     = {~br, br};
    DF     = {~bf, bf};
    @(posedge ECLK);
    #1;
    pi = 1 - pi;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pi = 0;
  endtask

  // Four idle cycles after reset so the rise lands on a non-strobe edge.
  task automatic prime();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Steps with RUNAIL held; returns the step index where LOCK first reads 1 (-1 if never).
  task automatic wait_lock(input int maxk, output int lock_at, output int nupd);
    lock_at = -1;
    nupd    = 0;
    for (int k = 1; k <= maxk; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (LOCK) begin
        lock_at = k;
        break;
      end
      if (UPDATE) nupd++;
    end
  endtask

  int lock_at, nupd;

  initial begin
    SLIP = 1'b0; RUNAIL = 1'b0; RSTAIL = 1'b0; RST = 1'b1; DR = '0; DF = '0;
    pat = 4'b1100;
    pi  = 0;

    // Reset, then ch0 pairs 10,01,11,00,11,00 and ch1 pairs 01,11,00,10,00,11.
    vecs[0] = '{1'b1, 2'b11, 2'b11, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 2'b11, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 2'b11, 2'b11, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 2'b10, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 2'b10, 2'b11, 8'b0111_1001, 1'b1};
    vecs[5] = '{1'b0, 2'b01, 2'b01, 8'b0111_1001, 1'b0};
    vecs[6] = '{1'b0, 2'b10, 2'b00, 8'b0010_1100, 1'b1};
    vecs[7] = '{1'b0, 2'b01, 2'b01, 8'b0010_1100, 1'b0};
    vecs[8] = '{1'b0, 2'b10, 2'b10, 8'b0011_1100, 1'b1};

    for (int i = 0; i < 9; i++) begin
      RST = vecs[i].rst;
      DR  = vecs[i].dr;
      DF  = vecs[i].df;
      @(posedge ECLK);
      #1;
      check($sformatf("vec%0d Q", i), Q, vecs[i].q);
      check($sformatf("vec%0d UPDATE", i), UPDATE, vecs[i].upd);
      check($sformatf("vec%0d LOCK", i), LOCK, 1'b0);
      check($sformatf("vec%0d SLIP_POS", i), SLIP_POS, 2'd0);
    end

    // Slip sequence on an aligned 1100 stream, continuing from the table.
    pat = 4'b1100;
    pi  = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("slip1 pos", SLIP_POS, 2'd1);
    check("slip1 upd", UPDATE, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);  // dropped: still busy
    check("slip busy pos", SLIP_POS, 2'd1);
    check("slip1 upd word", UPDATE, 1'b1);
    check("slip1 Q", Q, 8'h96);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("slip1 gap", UPDATE, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);  // boff 1->0: phase holds, strobe delayed
    check("slip2 pos", SLIP_POS, 2'd2);
    check("slip2 held upd", UPDATE, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("slip2 late upd", UPDATE, 1'b1);
    check("slip2 Q", Q, 8'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("slip2 gap", UPDATE, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("slip2 next Q0", Q[3:0], 4'b0011);

    // Training on an aligned stream.
    pat = 4'b1100;
    do_reset();
    prime();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    wait_lock(20, lock_at, nupd);
    check("train lock latency", lock_at, 8);
    check("train updates before lock", nupd, 4);
    check("train pos", SLIP_POS, 2'd0);
    pat = 4'b1010;  // data ignored once locked
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("locked hold", LOCK, 1'b1);

    // RST while locked.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst Q", Q, 8'h00);
    check("rst UPDATE", UPDATE, 1'b0);
    check("rst LOCK", LOCK, 1'b0);
    check("rst pos", SLIP_POS, 2'd0);

    // RSTAIL after two matches, then a fresh rise needs four new matches.
    pat = 4'b1100;
    do_reset();
    prime();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("rstail lock", LOCK, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rstail stays idle", LOCK, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    wait_lock(20, lock_at, nupd);
    check("retrain lock latency", lock_at, 7);

    // RSTAIL and rise together: RSTAIL wins, no training.
    do_reset();
    prime();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rstail beats rise", LOCK, 1'b0);

    // Misaligned stream: auto slips walk to position 3, then lock.
    pat = 4'b0110;
    do_reset();
    prime();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    wait_lock(40, lock_at, nupd);
    check("auto slip lock latency", lock_at, 17);
    check("auto slip pos", SLIP_POS, 2'd3);
    check("auto slip word", Q[3:0], 4'b1100);

    // External slip in LOCKED wraps position 3 -> 0.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("pos wrap", SLIP_POS, 2'd0);
    check("pos wrap lock", LOCK, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
